// File: rtl/fsm_key_driver_pkg.sv
// Shared constants and state encodings for the key driver and its shadow model.
package fsm_key_driver_pkg;

   localparam int               DEFAULT_KEY_W = 5;
   localparam logic [4:0]       DEFAULT_KEY   = 5'b10001;

   typedef enum logic {
      ST_KEY  = 1'b0,
      ST_PASS = 1'b1
   } ctrl_state_e;

   typedef enum logic [2:0] {
      S0 = 3'd0,
      S1 = 3'd1,
      S2 = 3'd2,
      S3 = 3'd3,
      S4 = 3'd4
   } shadow_state_e;

endpackage

// File: rtl/fsm_shadow_model.sv
// Lock-step functional model of the protected machine; predicts its registered out.
module fsm_shadow_model
   import fsm_key_driver_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic init,
   input  logic step,
   input  logic data_in,
   output logic exp_out
);

   shadow_state_e state, state_next;
   logic          exp_next;

   always_comb begin
      // NOTE: every output gets a default first, so no path leaves it unassigned and no latch is inferred.
      state_next = state;
      exp_next   = exp_out;
      if (init) begin
         state_next = S0;
         exp_next   = 1'b0;
      end else if (step) begin
         exp_next = 1'b0;
         case (state)
            S0:      state_next = data_in ? S2 : S1;
            S1:      state_next = data_in ? S2 : S3;
            S2:      state_next = data_in ? S4 : S3;
            S3:      state_next = S4;
            S4: begin
               state_next = data_in ? S0 : S1;
               exp_next   = data_in;
            end
            default: state_next = S0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of block order.
      if (!rst_n) begin
         state   <= S0;
         exp_out <= 1'b0;
      end else begin
         state   <= state_next;
         exp_out <= exp_next;
      end
   end

endmodule

// File: rtl/fsm_key_driver.sv
// Serially plays the unlock key into a locked FSM, then passes user data through
// and flags any divergence between the FSM's output and the shadow prediction.
module fsm_key_driver
   import fsm_key_driver_pkg::*;
#(
   parameter int               KEY_W = DEFAULT_KEY_W,
   parameter logic [KEY_W-1:0] KEY   = DEFAULT_KEY
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       data_in,
   input  logic       fsm_out,
   output logic       x_out,
   output logic       unlocked,
   output logic [2:0] key_cnt,
   output logic       exp_out,
   output logic       mismatch
);

   ctrl_state_e      state, state_next;
   logic [2:0]       cnt_next;
   logic             last_key_bit;
   logic [KEY_W-1:0] key_shifted;

   assign last_key_bit = (key_cnt == 3'(KEY_W - 1));
   // Shifting left by the count brings the next key bit to the MSB, so reset yields KEY[KEY_W-1].
   assign key_shifted  = KEY << key_cnt;
   assign unlocked     = (state == ST_PASS);

   always_comb begin
      state_next = state;
      cnt_next   = key_cnt;
      x_out      = data_in;
      unique case (state)
         ST_KEY: begin
            x_out    = key_shifted[KEY_W-1];
            cnt_next = key_cnt + 3'd1;
            if (last_key_bit) state_next = ST_PASS;
         end
         ST_PASS: x_out = data_in;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_KEY;
         key_cnt  <= 3'd0;
         mismatch <= 1'b0;
      end else begin
         state   <= state_next;
         key_cnt <= cnt_next;
         if (unlocked && (fsm_out != exp_out)) mismatch <= 1'b1;
      end
   end

   fsm_shadow_model u_shadow (
      .clk     (clk),
      .rst_n   (rst_n),
      .init    ((state == ST_KEY) && last_key_bit),
      .step    (unlocked),
      .data_in (data_in),
      .exp_out (exp_out)
   );

endmodule
